// File: rtl/jtframe_jt49_decim_pkg.sv
// Shared constants and types for the JT49 source-side decimator.
// Channel count, level width and the legal decimation range live here.
package jtframe_jt49_decim_pkg;

    localparam int NCH      = 5;
    localparam int W        = 10;
    localparam int DECW_MIN = 1;
    localparam int DECW_MAX = 8;

    typedef logic [W-1:0] level_t;

endpackage

// File: rtl/jtframe_jt49_decim_ch.sv
// Single-channel box averager: sums 2^DECW enabled ticks, then latches the
// truncated mean into dout at window end and restarts from zero.
module jtframe_jt49_decim_ch
    import jtframe_jt49_decim_pkg::*;
#(
    parameter int DECW = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   cen,
    input  logic   win_end,
    input  logic   mute,
    input  level_t level,
    output level_t dout
);

    logic [W+DECW-1:0] acc;
    logic [W+DECW-1:0] sum;
    level_t            term;

    assign term = mute ? '0 : level;
    // The closing tick is folded into the output, so the sum is formed combinationally
    assign sum  = acc + {{DECW{1'b0}}, term};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            dout <= '0;
        end else if (cen) begin
            if (win_end) begin
                dout <= sum[W+DECW-1:DECW];
                acc  <= '0;
            end else begin
                acc  <= sum;
            end
        end
    end

endmodule

// File: rtl/jtframe_jt49_decim.sv
// Five-channel PSG level decimator feeding the JT49 filter chain.
// Owns the window tick counter and the single-cycle sample strobe.
module jtframe_jt49_decim
    import jtframe_jt49_decim_pkg::*;
#(
    parameter int DECW = 3,
    parameter int W    = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic [W-1:0] ch0,
    input  logic [W-1:0] ch1,
    input  logic [W-1:0] ch2,
    input  logic [W-1:0] ch3,
    input  logic [W-1:0] ch4,
    input  logic [4:0]   mute,
    output logic [W-1:0] dout0,
    output logic [W-1:0] dout1,
    output logic [W-1:0] dout2,
    output logic [W-1:0] dout3,
    output logic [W-1:0] dout4,
    output logic         sample
);

    if (DECW < DECW_MIN || DECW > DECW_MAX) begin : g_bad_decw
        $error("jtframe_jt49_decim: DECW=%0d outside %0d..%0d", DECW, DECW_MIN, DECW_MAX);
    end
    if (W != jtframe_jt49_decim_pkg::W) begin : g_bad_w
        $error("jtframe_jt49_decim: W must be %0d", jtframe_jt49_decim_pkg::W);
    end

    logic [DECW-1:0] cnt;
    logic            win_end;
    level_t          ch   [NCH];
    level_t          dout [NCH];

    assign win_end = (cnt == '1);

    assign ch[0] = ch0;
    assign ch[1] = ch1;
    assign ch[2] = ch2;
    assign ch[3] = ch3;
    assign ch[4] = ch4;

    assign dout0 = dout[0];
    assign dout1 = dout[1];
    assign dout2 = dout[2];
    assign dout3 = dout[3];
    assign dout4 = dout[4];

    // cnt wraps from all-ones to zero on its own, closing the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sample <= 1'b0;
        end else begin
            sample <= cen & win_end;
            if (cen) cnt <= cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        jtframe_jt49_decim_ch #(
            .DECW (DECW)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .cen     (cen),
            .win_end (win_end),
            .mute    (mute[g]),
            .level   (ch[g]),
            .dout    (dout[g])
        );
    end

endmodule

// File: tb/tb_jtframe_jt49_decim.sv
// Directed bench for jtframe_jt49_decim: DECW=3 main instance plus a DECW=1
// instance for the continuous-enable case.
module tb_jtframe_jt49_decim;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b0;
    logic [9:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0;
    logic [4:0] mute = '0;
    logic [9:0] dout0, dout1, dout2, dout3, dout4;
    logic       sample;

    logic       cen1 = 1'b0;
    logic [9:0] r_ch2 = '0;
    logic [9:0] zero10 = '0;
    logic [9:0] e0, e1, e2, e3, e4;
    logic       sample1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int npulse0 = 0;
    int consec0 = 0, consec1 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    logic last_s, next_s;
    int   last_cyc, p1, pulses_before;

    jtframe_jt49_decim #(.DECW(3), .W(10)) u_dut (
        .clk(clk), .rst(rst), .cen(cen),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
        .mute(mute),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3), .dout4(dout4),
        .sample(sample)
    );

    jtframe_jt49_decim #(.DECW(1), .W(10)) u_dut1 (
        .clk(clk), .rst(rst), .cen(cen1),
        .ch0(zero10), .ch1(zero10), .ch2(r_ch2), .ch3(zero10), .ch4(zero10),
        .mute(5'b0),
        .dout0(e0), .dout1(e1), .dout2(e2), .dout3(e3), .dout4(e4),
        .sample(sample1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample) npulse0 <= npulse0 + 1;
        if (sample && prev0) consec0 <= consec0 + 1;
        if (sample1 && prev1) consec1 <= consec1 + 1;
        prev0 <= sample;
        prev1 <= sample1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int exp);
        chk({tag, "_d0"}, int'(dout0), exp);
        chk({tag, "_d1"}, int'(dout1), exp);
        chk({tag, "_d2"}, int'(dout2), exp);
        chk({tag, "_d3"}, int'(dout3), exp);
        chk({tag, "_d4"}, int'(dout4), exp);
    endtask

    // One cen tick followed by three idle clks; captures sample right after
    // the registering edge and one clk later.
    task automatic tick();
        cen = 1'b1;
        @(posedge clk); #1;
        cen = 1'b0;
        last_s   = sample;
        last_cyc = cyc;
        @(posedge clk); #1;
        next_s = sample;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic set_all(input logic [9:0] v);
        ch0 = v; ch1 = v; ch2 = v; ch3 = v; ch4 = v;
    endtask

    initial begin
        // Reset
        #2 rst = 1'b1;
        #10;
        chk_all("reset", 0);
        chk("reset_sample", int'(sample), 0);
        chk("reset_sample1", int'(sample1), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Constant level 1023
        set_all(10'd1023);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("const_nopulse%0d", i), int'(last_s), 0);
        end
        tick();
        chk("const_pulse", int'(last_s), 1);
        chk("const_pulse_width", int'(next_s), 0);
        chk_all("const", 1023);
        p1 = last_cyc;

        // Truncation: ch0 alternates 0/1, sum 4 -> 0
        for (int i = 0; i < 8; i++) begin
            ch0 = (i % 2 == 1) ? 10'd1 : 10'd0;
            tick();
        end
        chk("trunc_pulse", int'(last_s), 1);
        chk("pulse_spacing", last_cyc - p1, 32);
        chk("trunc_d0", int'(dout0), 0);
        chk("trunc_d1", int'(dout1), 1023);
        ch0 = 10'd3;
        for (int i = 0; i < 8; i++) tick();
        chk("three_d0", int'(dout0), 3);

        // Mute mid-window on ch1
        ch1 = 10'd800;
        for (int i = 0; i < 8; i++) begin
            mute = (i >= 4) ? 5'b00010 : 5'b00000;
            tick();
        end
        chk("mute_pulse", int'(last_s), 1);
        chk("mute_half_d1", int'(dout1), 400);
        chk("mute_d0", int'(dout0), 3);
        chk("mute_d2", int'(dout2), 1023);
        for (int i = 0; i < 8; i++) tick();
        chk("mute_full_d1", int'(dout1), 0);
        chk("mute_full_d4", int'(dout4), 1023);
        mute = 5'b0;

        // Idle cen mid-window: 3 ticks, 1000 idle clks with toggling inputs, 5 ticks
        set_all(10'd100);
        for (int i = 0; i < 3; i++) tick();
        pulses_before = npulse0;
        for (int i = 0; i < 1000; i++) begin
            set_all(10'($urandom_range(0, 1023)));
            mute = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
        end
        chk("idle_no_pulse", npulse0 - pulses_before, 0);
        chk("idle_d1_hold", int'(dout1), 0);
        chk("idle_d2_hold", int'(dout2), 1023);
        set_all(10'd100);
        mute = 5'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("idle_resume_nopulse%0d", i), int'(last_s), 0);
        end
        tick();
        chk("idle_resume_pulse", int'(last_s), 1);
        chk_all("idle_resume", 100);

        // Async reset mid-window
        set_all(10'd600);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0);
        chk("async_rst_sample", int'(sample), 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("post_rst_nopulse%0d", i), int'(last_s), 0);
        end
        tick();
        chk("post_rst_pulse", int'(last_s), 1);
        chk_all("post_rst", 600);

        // DECW=1 with cen held high and a ramp on ch2
        r_ch2 = 10'd0;
        cen1  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            r_ch2 = 10'(i);
            chk($sformatf("cont_sample%0d", i), int'(sample1), (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) chk($sformatf("cont_d2_%0d", i), int'(e2), i - 2);
        end
        cen1 = 1'b0;
        @(posedge clk); #1;

        chk("no_consec0", consec0, 0);
        chk("no_consec1", consec1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
